// File: rtl/bcd_xs3_serial_codec.sv
// Bit-serial BCD <-> Excess-3 converter, LSB-first, one digit per 4 accepted bits.
// Define BCD_CODE_ERR_CHECK_EN to build the illegal-code detector driving digit_err.
module bcd_xs3_serial_codec #(
    parameter int DIGITS = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic x,
    input  logic x_valid,
    input  logic mode,
    output logic z,
    output logic z_valid,
    output logic digit_done,
    output logic digit_err,
    output logic word_done
);

    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [DW-1:0] D_LAST = DW'(DIGITS - 1);

    logic [1:0]    b;
    logic [DW-1:0] d;
    logic          c;
    logic          m;

    logic first_bit;
    logic m_eff;
    logic k;
    logic c_in;
    logic z_nxt;
    logic c_nxt;
    logic last_bit;
    logic last_digit;
    logic err_nxt;

    // Mode is taken live on the first bit of a word so that bit already uses it.
    always_comb begin
        first_bit  = (b == 2'd0) && (d == '0);
        m_eff      = first_bit ? mode : m;
        k          = ~b[1];
        c_in       = (b == 2'd0) ? 1'b0 : c;
        z_nxt      = x ^ k ^ c_in;
        c_nxt      = m_eff ? ((~x & (k | c_in)) | (k & c_in))
                           : ((x & k) | (x & c_in) | (k & c_in));
        last_bit   = (b == 2'd3);
        last_digit = (d == D_LAST);
    end

`ifdef BCD_CODE_ERR_CHECK_EN
    logic [2:0] hist;
    logic [3:0] digit_val;

    always_comb begin
        digit_val = {x, hist};
        err_nxt   = 1'b0;
        if (last_bit) begin
            if (m_eff)
                err_nxt = (digit_val < 4'd3) || (digit_val > 4'd12);
            else
                err_nxt = (digit_val > 4'd9);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            hist <= '0;
        end else if (x_valid) begin
            case (b)
                2'd0:    hist[0] <= x;
                2'd1:    hist[1] <= x;
                2'd2:    hist[2] <= x;
                default: hist    <= hist;
            endcase
        end
    end
`else
    always_comb err_nxt = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            b          <= '0;
            d          <= '0;
            c          <= 1'b0;
            m          <= 1'b0;
            z          <= 1'b0;
            z_valid    <= 1'b0;
            digit_done <= 1'b0;
            digit_err  <= 1'b0;
            word_done  <= 1'b0;
        end else if (x_valid) begin
            z          <= z_nxt;
            z_valid    <= 1'b1;
            digit_done <= last_bit;
            digit_err  <= err_nxt;
            word_done  <= last_bit && last_digit;
            c          <= c_nxt;
            b          <= b + 2'd1;
            if (first_bit)
                m <= mode;
            if (last_bit)
                d <= last_digit ? '0 : d + DW'(1);
        end else begin
            z          <= 1'b0;
            z_valid    <= 1'b0;
            digit_done <= 1'b0;
            digit_err  <= 1'b0;
            word_done  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bcd_xs3_serial_codec.sv
// Directed self-checking bench for bcd_xs3_serial_codec (DIGITS = 4).
// digit_err expectations follow whether BCD_CODE_ERR_CHECK_EN is defined.
module tb_bcd_xs3_serial_codec;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic x = 1'b0;
    logic x_valid = 1'b0;
    logic mode = 1'b0;
    logic z, z_valid, digit_done, digit_err, word_done;

    int checks = 0;
    int errors = 0;

`ifdef BCD_CODE_ERR_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    bcd_xs3_serial_codec #(.DIGITS(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .x          (x),
        .x_valid    (x_valid),
        .mode       (mode),
        .z          (z),
        .z_valid    (z_valid),
        .digit_done (digit_done),
        .digit_err  (digit_err),
        .word_done  (word_done)
    );

    always #5 clock = ~clock;

    task automatic do_reset();
        reset   = 1'b0;
        x_valid = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    task automatic idle_cycle();
        x_valid = 1'b0;
        @(posedge clock);
        #1;
    endtask

    // Sends one bit; the returned flags are the registered outputs for that bit.
    task automatic send_bit(input logic xb, input logic md,
                            output logic zb, output logic zv, output logic dd,
                            output logic de, output logic wd);
        x       = xb;
        mode    = md;
        x_valid = 1'b1;
        @(posedge clock);
        #1;
        x_valid = 1'b0;
        zb = z; zv = z_valid; dd = digit_done; de = digit_err; wd = word_done;
    endtask

    task automatic send_digit(input logic [3:0] val, input logic md0, input logic md_rest,
                              output logic [3:0] zo, output logic [3:0] zv,
                              output logic [3:0] dd, output logic [3:0] de,
                              output logic [3:0] wd);
        for (int i = 0; i < 4; i++) begin
            send_bit(val[i], (i == 0) ? md0 : md_rest, zo[i], zv[i], dd[i], de[i], wd[i]);
        end
    endtask

    task automatic test_reset();
        reset   = 1'b0;
        x_valid = 1'b1;
        x       = 1'b1;
        @(posedge clock);
        #1;
        checks++;
        if ({z, z_valid, digit_done, digit_err, word_done} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b want 00000",
                     {z, z_valid, digit_done, digit_err, word_done});
        end
        x_valid = 1'b0;
        reset   = 1'b1;
    endtask

    task automatic test_bcd_to_xs3();
        logic [3:0] zo, zv, dd, de, wd;
        do_reset();
        send_digit(4'd5, 1'b0, 1'b0, zo, zv, dd, de, wd);
        checks++;
        if (zo !== 4'd8) begin errors++; $display("FAIL b2x_5 z got %0d want 8", zo); end
        checks++;
        if (zv !== 4'b1111) begin errors++; $display("FAIL b2x_5 z_valid got %b want 1111", zv); end
        checks++;
        if (dd !== 4'b1000) begin errors++; $display("FAIL b2x_5 digit_done got %b want 1000", dd); end
        checks++;
        if (de !== 4'b0000) begin errors++; $display("FAIL b2x_5 digit_err got %b want 0000", de); end
    endtask

    task automatic test_xs3_to_bcd();
        logic [3:0] zo, zv, dd, de, wd;
        do_reset();
        send_digit(4'd8, 1'b1, 1'b1, zo, zv, dd, de, wd);
        checks++;
        if (zo !== 4'd5) begin errors++; $display("FAIL x2b_8 z got %0d want 5", zo); end
        checks++;
        if (de !== 4'b0000) begin errors++; $display("FAIL x2b_8 digit_err got %b want 0000", de); end
        checks++;
        if (dd !== 4'b1000) begin errors++; $display("FAIL x2b_8 digit_done got %b want 1000", dd); end
    endtask

    task automatic test_word();
        logic [3:0] zo, zv, dd, de, wd;
        logic [3:0] in_a  [4] = '{4'd9, 4'd0, 4'd3, 4'd7};
        logic [3:0] exp_a [4] = '{4'd12, 4'd3, 4'd6, 4'd10};
        logic [3:0] in_b  [4] = '{4'd12, 4'd3, 4'd6, 4'd13};
        logic [3:0] exp_b [4] = '{4'd9, 4'd0, 4'd3, 4'd10};
        logic [3:0] err_b [4];
        err_b = '{4'b0000, 4'b0000, 4'b0000, ERR_EN ? 4'b1000 : 4'b0000};
        do_reset();
        // mode driven to 1 on every bit but the first: must be ignored.
        for (int i = 0; i < 4; i++) begin
            send_digit(in_a[i], (i == 0) ? 1'b0 : 1'b1, 1'b1, zo, zv, dd, de, wd);
            checks++;
            if (zo !== exp_a[i]) begin
                errors++; $display("FAIL word_a digit%0d z got %0d want %0d", i, zo, exp_a[i]);
            end
            checks++;
            if (wd !== ((i == 3) ? 4'b1000 : 4'b0000)) begin
                errors++; $display("FAIL word_a digit%0d word_done got %b", i, wd);
            end
            checks++;
            if (de !== 4'b0000) begin
                errors++; $display("FAIL word_a digit%0d digit_err got %b want 0000", i, de);
            end
        end
        // Second word: mode sampled afresh at digit 0 despite mode=0 later.
        for (int i = 0; i < 4; i++) begin
            send_digit(in_b[i], (i == 0) ? 1'b1 : 1'b0, 1'b0, zo, zv, dd, de, wd);
            checks++;
            if (zo !== exp_b[i]) begin
                errors++; $display("FAIL word_b digit%0d z got %0d want %0d", i, zo, exp_b[i]);
            end
            checks++;
            if (de !== err_b[i]) begin
                errors++; $display("FAIL word_b digit%0d digit_err got %b want %b", i, de, err_b[i]);
            end
            checks++;
            if (wd !== ((i == 3) ? 4'b1000 : 4'b0000)) begin
                errors++; $display("FAIL word_b digit%0d word_done got %b", i, wd);
            end
        end
    endtask

    task automatic test_illegal();
        logic [3:0] zo, zv, dd, de, wd;
        do_reset();
        send_digit(4'd10, 1'b0, 1'b0, zo, zv, dd, de, wd);
        checks++;
        if (zo !== 4'd13) begin errors++; $display("FAIL ill_b2x_10 z got %0d want 13", zo); end
        checks++;
        if (de !== (ERR_EN ? 4'b1000 : 4'b0000)) begin
            errors++; $display("FAIL ill_b2x_10 digit_err got %b want %b", de, ERR_EN ? 4'b1000 : 4'b0000);
        end
        do_reset();
        send_digit(4'd1, 1'b1, 1'b1, zo, zv, dd, de, wd);
        checks++;
        if (zo !== 4'd14) begin errors++; $display("FAIL ill_x2b_1 z got %0d want 14", zo); end
        checks++;
        if (de !== (ERR_EN ? 4'b1000 : 4'b0000)) begin
            errors++; $display("FAIL ill_x2b_1 digit_err got %b want %b", de, ERR_EN ? 4'b1000 : 4'b0000);
        end
        send_digit(4'd3, 1'b1, 1'b1, zo, zv, dd, de, wd);
        checks++;
        if (zo !== 4'd0 || de !== 4'b0000) begin
            errors++; $display("FAIL edge_x2b_3 z/err got %0d/%b want 0/0000", zo, de);
        end
    endtask

    task automatic test_stall();
        logic [3:0] zo, zv, dd, de, wd;
        logic [3:0] val = 4'd2;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            send_bit(val[i], 1'b0, zo[i], zv[i], dd[i], de[i], wd[i]);
            if (i == 1) begin
                for (int g = 0; g < 3; g++) begin
                    idle_cycle();
                    checks++;
                    if ({z_valid, digit_done, digit_err, word_done} !== 4'b0) begin
                        errors++;
                        $display("FAIL stall_gap%0d flags got %b want 0000", g,
                                 {z_valid, digit_done, digit_err, word_done});
                    end
                end
            end
        end
        checks++;
        if (zo !== 4'd5 || zv !== 4'b1111) begin
            errors++; $display("FAIL stall_2 z/zv got %0d/%b want 5/1111", zo, zv);
        end
        checks++;
        if (dd !== 4'b1000) begin errors++; $display("FAIL stall_2 digit_done got %b want 1000", dd); end
    endtask

    task automatic test_reset_mid();
        logic [3:0] zo, zv, dd, de, wd;
        logic zb, zvb, ddb, deb, wdb;
        do_reset();
        send_bit(1'b1, 1'b1, zb, zvb, ddb, deb, wdb);
        send_bit(1'b1, 1'b1, zb, zvb, ddb, deb, wdb);
        do_reset();
        send_digit(4'd2, 1'b0, 1'b0, zo, zv, dd, de, wd);
        checks++;
        if (zo !== 4'd5) begin errors++; $display("FAIL rmid_2 z got %0d want 5", zo); end
        checks++;
        if (dd !== 4'b1000) begin errors++; $display("FAIL rmid_2 digit_done got %b want 1000", dd); end
        checks++;
        if (wd !== 4'b0000) begin errors++; $display("FAIL rmid_2 word_done got %b want 0000", wd); end
        for (int i = 1; i < 4; i++) begin
            send_digit(4'd4, 1'b0, 1'b0, zo, zv, dd, de, wd);
            checks++;
            if (zo !== 4'd7 || wd !== ((i == 3) ? 4'b1000 : 4'b0000)) begin
                errors++; $display("FAIL rmid_digit%0d z/word_done got %0d/%b", i, zo, wd);
            end
        end
    endtask

    initial begin
        test_reset();
        test_bcd_to_xs3();
        test_xs3_to_bcd();
        test_word();
        test_illegal();
        test_stall();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/bcd_xs3_serial_codec.md
BCD_XS3_SERIAL_CODEC -- requirements
Module: bcd_xs3_serial_codec

Interface
REQ-001 The block SHALL have parameter DIGITS, default 4, giving the number of 4-bit digits per word (legal range 1..8).
REQ-002 The block SHALL have port clock, input, 1 bit: rising-edge clock for all state.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-004 The block SHALL have port x, input, 1 bit: serial code bit, LSB of each digit first, digit 0 first.
REQ-005 The block SHALL have port x_valid, input, 1 bit: when high, x carries a bit this cycle.
REQ-006 The block SHALL have port mode, input, 1 bit: 0 = BCD->Excess-3 (add 3), 1 = Excess-3->BCD (subtract 3).
REQ-007 The block SHALL have port z, output, 1 bit: converted serial bit.
REQ-008 The block SHALL have port z_valid, output, 1 bit: z is valid this cycle.
REQ-009 The block SHALL have port digit_done, output, 1 bit: this z is bit 3 of a digit.
REQ-010 The block SHALL have port digit_err, output, 1 bit: the digit just completed is an illegal code.
REQ-011 The block SHALL have port word_done, output, 1 bit: this z is bit 3 of digit DIGITS-1.

Function
REQ-012 Each accepted input bit (x_valid=1 at a rising edge) SHALL produce exactly one z bit with z_valid=1 in the following cycle (1-cycle latency, registered outputs).
REQ-013 Any cycle that accepts no bit SHALL have z_valid, digit_done, digit_err and word_done all 0 in the following cycle, and SHALL leave all state unchanged (stall).
REQ-014 The state SHALL comprise bit index b (0..3), digit index d (0..DIGITS-1), carry/borrow c, latched mode m, and a 3-bit digit history.
REQ-015 Constant bit k SHALL be 1 for b=0 and b=1, and 0 for b=2 and b=3 (constant 4'b0011).
REQ-016 With m=0, the block SHALL compute z = x^k^c and c' = majority(x,k,c).
REQ-017 With m=1, the block SHALL compute z = x^k^c and c' = (~x&(k|c))|(k&c) (borrow).
REQ-018 c SHALL clear at b=0 of every digit, and carry or borrow out of b=3 SHALL be discarded; digits are converted independently.
REQ-019 mode SHALL be sampled into m only when accepting b=0 of d=0; mode changes mid-word SHALL be ignored.
REQ-020 b SHALL increment on each accepted bit and wrap 3->0; d SHALL increment when b wraps and wrap DIGITS-1->0.
REQ-021 digit_done SHALL be 1 alongside z for b=3; word_done SHALL be 1 alongside z for b=3 and d=DIGITS-1.
REQ-022 digit_err SHALL be 1 alongside digit_done when the full input digit is >9 (m=0), or <3 or >12 (m=1).
REQ-023 For an illegal digit, z SHALL still be the arithmetic result per REQ-016/017.

Reset
REQ-024 When reset=0 at a rising edge, the block SHALL set b=0, d=0, c=0, m=0, history=0, and z, z_valid, digit_done, digit_err, word_done to 0.
REQ-025 Reset SHALL take priority over x_valid, and a reset mid-word SHALL discard the partial digit and word.
REQ-026 The first accepted bit after reset SHALL be treated as b=0 of d=0.

Configuration
REQ-027 With macro BCD_CODE_ERR_CHECK_EN defined, digit_err SHALL behave per REQ-022.
REQ-028 Without BCD_CODE_ERR_CHECK_EN, digit_err SHALL be constant 0 and the digit history register SHALL not be built; z behaviour SHALL be identical in both builds.

Verification
REQ-029 mode=0, digit 5 as bits 1,0,1,0 -> z = 0,0,0,1 (8); digit_done on the 4th bit; digit_err=0.
REQ-030 mode=1, digit 8 as bits 0,0,0,1 -> z = 1,0,1,0 (5); digit_err=0.
REQ-031 mode=0, DIGITS=4, digits 9,0,3,7 -> outputs 12,3,6,10; word_done only with the 16th bit; mode toggled mid-word has no effect.
REQ-032 BCD_CODE_ERR_CHECK_EN defined: mode=0 digit 10 -> z = 1101 (13), digit_err=1; mode=1 digit 1 -> digit_err=1.
REQ-033 Digit 2 sent with x_valid low for 3 cycles between bits 1 and 2 -> z_valid gaps match; result 5.
REQ-034 reset=0 after 2 bits of a digit, then digit 2 (mode=0) -> z = 5, digit_done on its 4th bit, d restarts at 0.
